// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared definitions for the seven-segment scan decoder:
//            active-low glyph constants for hex 0-F ({g,f,e,d,c,b,a}),
//            the scan FSM state type and its encodings, and anode helpers
//            (active-anode count and one-hot index encode).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}; a '0' lights the segment.
  localparam logic [6:0] c_GLYPH_0 = 7'h40;
  localparam logic [6:0] c_GLYPH_1 = 7'h79;
  localparam logic [6:0] c_GLYPH_2 = 7'h24;
  localparam logic [6:0] c_GLYPH_3 = 7'h30;
  localparam logic [6:0] c_GLYPH_4 = 7'h19;
  localparam logic [6:0] c_GLYPH_5 = 7'h12;
  localparam logic [6:0] c_GLYPH_6 = 7'h02;
  localparam logic [6:0] c_GLYPH_7 = 7'h78;
  localparam logic [6:0] c_GLYPH_8 = 7'h00;
  localparam logic [6:0] c_GLYPH_9 = 7'h10;
  localparam logic [6:0] c_GLYPH_A = 7'h08;
  localparam logic [6:0] c_GLYPH_B = 7'h03;
  localparam logic [6:0] c_GLYPH_C = 7'h46;
  localparam logic [6:0] c_GLYPH_D = 7'h21;
  localparam logic [6:0] c_GLYPH_E = 7'h06;
  localparam logic [6:0] c_GLYPH_F = 7'h0E;

  // Scan FSM state type and encodings.
  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE   = 2'd0;
  localparam state_t c_ST_FILTER = 2'd1;
  localparam state_t c_ST_HOLD   = 2'd2;

  // Anode-count reference values.
  localparam logic [2:0] c_AN_CNT_NONE = 3'd0;
  localparam logic [2:0] c_AN_CNT_ONE  = 3'd1;

  // Number of active (low) anodes in an active-low anode vector.
  function automatic logic [2:0] an_active_count(input logic [3:0] an_n);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int k = 0; k < 4; k++) begin
      cnt = cnt + {2'b00, ~an_n[k]};
    end
    return cnt;
  endfunction

  // Index of the lowest active anode; meaningful only when exactly one is active.
  function automatic logic [1:0] an_index(input logic [3:0] an_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!an_n[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_glyph_decode
// Purpose  : Combinational decode of an active-low seven-segment glyph into
//            its hex value. Patterns outside the 16 standard hex glyphs
//            return 4'h0 with illegal asserted.
// Ports    : seg     [6:0] in  - active-low segments {g,f,e,d,c,b,a}
//            hex     [3:0] out - decoded hex value
//            illegal       out - pattern is not a hex glyph
// Revision : 1.0 - initial release
// ============================================================================
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       illegal
);

  always_comb begin
    hex     = 4'h0;
    illegal = 1'b0;
    case (seg)
      c_GLYPH_0: hex = 4'h0;
      c_GLYPH_1: hex = 4'h1;
      c_GLYPH_2: hex = 4'h2;
      c_GLYPH_3: hex = 4'h3;
      c_GLYPH_4: hex = 4'h4;
      c_GLYPH_5: hex = 4'h5;
      c_GLYPH_6: hex = 4'h6;
      c_GLYPH_7: hex = 4'h7;
      c_GLYPH_8: hex = 4'h8;
      c_GLYPH_9: hex = 4'h9;
      c_GLYPH_A: hex = 4'hA;
      c_GLYPH_B: hex = 4'hB;
      c_GLYPH_C: hex = 4'hC;
      c_GLYPH_D: hex = 4'hD;
      c_GLYPH_E: hex = 4'hE;
      c_GLYPH_F: hex = 4'hF;
      default:   illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Recovers the four hex digits shown on a multiplexed, active-low
//            seven-segment display by watching its segment/anode drive.
//            Each pattern must be seen unchanged for STABLE_CYCLES samples
//            before it is captured; a pattern is captured once per hold.
// Config   : define SEG_DP_CAPTURE_EN to capture the decimal point into
//            dp_out (and to treat dp changes as pattern changes). Without it
//            the dp input is ignored and dp_out does not exist.
// Ports    : clk              in  - clock, rising edge
//            rst              in  - synchronous active-high reset
//            seg      [6:0]   in  - active-low segments {g,f,e,d,c,b,a}
//            an       [3:0]   in  - active-low anodes, an[i] = digit i
//            dp               in  - active-low decimal point
//            digits   [15:0]  out - digit i value in digits[4i+3:4i]
//            digit_valid[3:0] out - digit i captured since reset
//            pat_err  [3:0]   out - digit i last capture was not a hex glyph
//            an_err           out - sticky: two or more anodes seen active
//            frame_done       out - one-cycle pulse, all four digits captured
//            dp_out   [3:0]   out - captured decimal point, active-high
//                                   (SEG_DP_CAPTURE_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  pat_err,
  output logic        an_err,
  output logic        frame_done
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [3:0]  dp_out
`endif
);

  // Count value one below the capture threshold.
  localparam logic [7:0] c_CNT_LAST = 8'(STABLE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Sample stage. The sample word carries dp only when it is being captured,
  // so a dp-only change restarts the filter only in that build.
  // --------------------------------------------------------------------------
`ifdef SEG_DP_CAPTURE_EN
  localparam int c_SMP_W = 12;
  logic [c_SMP_W-1:0] w_smp_in;
  assign w_smp_in = {an, seg, dp};
`else
  localparam int c_SMP_W = 11;
  logic [c_SMP_W-1:0] w_smp_in;
  logic               w_unused_dp;
  assign w_smp_in    = {an, seg};
  assign w_unused_dp = dp;
`endif

  logic [c_SMP_W-1:0] r_smp;   // current sample, the only thing decisions use
  logic [c_SMP_W-1:0] r_prev;  // sample evaluated on the previous cycle

  // Pure data pipeline: the FSM reset already discards whatever it holds,
  // so these registers carry no reset.
  always_ff @(posedge clk) begin
    r_smp  <= w_smp_in;
    r_prev <= r_smp;
  end

  logic [3:0] w_an;
  logic [6:0] w_seg;
  logic [2:0] w_an_cnt;
  logic [1:0] w_idx;
  logic       w_same;

  assign w_an     = r_smp[c_SMP_W-1 -: 4];
  assign w_seg    = r_smp[c_SMP_W-5 -: 7];
  assign w_an_cnt = an_active_count(w_an);
  assign w_idx    = an_index(w_an);
  assign w_same   = (r_smp == r_prev);

  // --------------------------------------------------------------------------
  // Glyph decode of the current sample.
  // --------------------------------------------------------------------------
  logic [3:0] w_hex;
  logic       w_illegal;

  seg_glyph_decode u_glyph_decode (
    .seg     (w_seg),
    .hex     (w_hex),
    .illegal (w_illegal)
  );

  // --------------------------------------------------------------------------
  // Scan FSM: IDLE -> FILTER -> HOLD.
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_capture;
  logic       w_an_err_set;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_an_err_set = 1'b0;

    if (w_an_cnt > c_AN_CNT_ONE) begin
      // Overlapping anodes: abandon any filter regardless of state.
      w_state_nxt  = c_ST_IDLE;
      w_cnt_nxt    = 8'd0;
      w_an_err_set = 1'b1;
    end else if (w_an_cnt == c_AN_CNT_NONE) begin
      w_state_nxt = c_ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        c_ST_FILTER: begin
          if (!w_same) begin
            w_cnt_nxt = 8'd1;
          end else if (r_cnt == c_CNT_LAST) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = r_cnt + 8'd1;
            w_state_nxt = c_ST_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        c_ST_HOLD: begin
          // An unchanged pattern is never captured twice.
          if (!w_same) begin
            w_state_nxt = c_ST_FILTER;
            w_cnt_nxt   = 8'd1;
          end
        end
        default: begin
          w_state_nxt = c_ST_FILTER;
          w_cnt_nxt   = 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Capture registers and frame tracking.
  // --------------------------------------------------------------------------
  logic [15:0] r_digits;
  logic [3:0]  r_digit_valid;
  logic [3:0]  r_pat_err;
  logic        r_an_err;
  logic        r_frame_done;
  logic [3:0]  r_frame;
  logic [3:0]  w_frame_nxt;

  assign w_frame_nxt = r_frame | (4'b0001 << w_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits      <= 16'h0000;
      r_digit_valid <= 4'h0;
      r_pat_err     <= 4'h0;
      r_an_err      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame       <= 4'h0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_an_err_set) begin
        r_an_err <= 1'b1;
      end
      if (w_capture) begin
        r_digits[{w_idx, 2'b00} +: 4] <= w_hex;
        r_digit_valid[w_idx]          <= 1'b1;
        r_pat_err[w_idx]              <= w_illegal;
        // The pulse and the mask clear land with the completing capture.
        if (w_frame_nxt == 4'hF) begin
          r_frame_done <= 1'b1;
          r_frame      <= 4'h0;
        end else begin
          r_frame <= w_frame_nxt;
        end
      end
    end
  end

`ifdef SEG_DP_CAPTURE_EN
  logic [3:0] r_dp_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_out <= 4'h0;
    end else if (w_capture) begin
      r_dp_out[w_idx] <= ~r_smp[0];
    end
  end

  assign dp_out = r_dp_out;
`endif

  assign digits      = r_digits;
  assign digit_valid = r_digit_valid;
  assign pat_err     = r_pat_err;
  assign an_err      = r_an_err;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire
